shift_sequencer: RTL and testbench
==================================

# shift_sequencer

- Multi-cycle shift unit for the ALU's shift ops: SLL, SRL, SRA.
- Processes one logarithmic shift stage per clock (1, 2, 4, 8, 16) on a single registered datapath, under a small FSM.
- Requests are accepted with a valid/ready handshake; the result is returned the same way.
- Sits beside the single-cycle ALU. It is intended for area-constrained builds where a full 5-level barrel shifter in the execute path is too costly.

## Interface

Parameters:
- N, 32, datapath width. Only 32 is supported because the shift amount is fixed at 5 bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  2  operation code:
  - 00 SLL
  - 01 SRL
  - 10 SRA
  - 11 reserved: passes the operand through unchanged.
- req_a  in  N  operand.
- req_shamt  in  5  shift amount.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_data  out  N  result.
- busy  out  1  high in the SHIFT and DONE states.

## Operation

FSM states: IDLE, SHIFT, DONE.

IDLE:
- req_ready = 1.
- When req_valid is high on an edge (acceptance edge):
  - Capture req_a into the working register, which drives rsp_data.
  - Capture op, the shamt mask, and sign = req_a[31].
  - Stage index k is set to 0.
  - Next state is SHIFT, or DONE directly if early exit is enabled and shamt = 0.
- req_op, req_a and req_shamt are ignored whenever req_ready = 0.

SHIFT, one stage per edge:
- If mask[k] = 1, shift the working register by 2^k:
  - SLL fills with zeros from the LSB.
  - SRL fills with zeros from the MSB.
  - SRA fills with the captured sign bit from the MSB.
  - Reserved op: no change.
- Then clear mask[k] and advance k.
- After stage k = 4 (or when the mask is empty with early exit enabled), next state is DONE.

DONE:
- rsp_valid = 1; rsp_data is held stable.
- On rsp_valid && rsp_ready, next state is IDLE.
- No new request is accepted in DONE.

Arithmetic rules:
- The sign bit is sampled once at acceptance. Stages never re-sample the MSB.
- Shift amounts are never masked beyond 5 bits; shamt = 31 is legal.

Reset:
- Asynchronous. The state returns to IDLE immediately.
- Output reset values:
  - req_ready = 0 while rst is high, 1 after release.
  - rsp_valid = 0.
  - rsp_data = 0.
  - busy = 0.
- Reset in the middle of an operation abandons it. No response is ever produced for that request.

## Timing

- req_ready, rsp_valid and busy are decoded from registered state only. There are no combinational input-to-output paths.
- Acceptance edge = E0.
- Latency with early exit off: fixed. SHIFT spans E1..E5, and rsp_valid is high in the cycle after E5.
- Latency with early exit on: rsp_valid is high in the cycle after E(p), where p = popcount(shamt). For shamt = 0, rsp_valid is high in the cycle after E0.
- Throughput: at most one request per (latency + 2) cycles. The earliest next acceptance is the edge after the response handshake edge.
- Back-pressure: while rsp_ready = 0 in DONE, rsp_data, rsp_valid and busy hold indefinitely.
- req_valid must stay asserted until req_ready is seen; the block does not latch a request that was dropped early.

## Configuration

- SHIFT_SEQ_EARLY_EXIT_EN:
  - Defined: SHIFT visits only the set bits of shamt, lowest first, one per edge, and exits when the mask is empty.
  - Undefined: all 5 stages always execute, and latency is constant regardless of shamt.
- Results are identical in both builds; only latency differs.

## Test plan

- SRA, a = 0x80000000, shamt = 31: rsp_data = 0xFFFFFFFF. rsp_valid is high in the cycle after E5 in both builds (popcount = 5).
- SRL, a = 0x80000000, shamt = 4: rsp_data = 0x08000000. SRA with the same operands: rsp_data = 0xF8000000.
- SLL, a = 0x00000001, shamt = 31: rsp_data = 0x80000000. Reserved op 11, a = 0x12345678, shamt = 7: rsp_data = 0x12345678.
- Back-pressure: hold rsp_ready = 0 for 3 cycles in DONE. rsp_data stays stable, req_ready = 0 and busy = 1. Then assert rsp_ready: after that edge busy = 0 and req_ready = 1.
- Reset mid-operation: assert rst two cycles after acceptance. Outputs are 0 immediately, and no rsp_valid follows. After release, req_ready = 1, and a new SLL 0x1 by 1 returns 0x2.
- shamt = 0, a = 0xDEADBEEF, SRA: rsp_data = 0xDEADBEEF, valid after E0 with SHIFT_SEQ_EARLY_EXIT_EN defined and after E5 without. With the macro defined, shamt = 0x10 returns valid after E1.

Source files
------------

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA unit: one logarithmic stage (1,2,4,8,16) per clock behind valid/ready.
// Optional feature macro: SHIFT_SEQ_EARLY_EXIT_EN (visit only the set bits of shamt).
module shift_sequencer #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_op,
  input  logic [N-1:0] req_a,
  input  logic [4:0]   req_shamt,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_data,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  typedef enum logic [1:0] {OP_SLL = 2'b00, OP_SRL = 2'b01, OP_SRA = 2'b10, OP_RSV = 2'b11} op_e;

  state_e       state_q, state_d;
  op_e          op_q, op_d;
  logic [N-1:0] data_q, data_d;
  logic [4:0]   mask_q, mask_d;
  logic         sign_q, sign_d;
  logic [2:0]   stage;
`ifndef SHIFT_SEQ_EARLY_EXIT_EN
  logic [2:0]   k_q, k_d;
`endif

  // Vacated MSBs of an arithmetic shift take the sign captured at acceptance, never the live MSB.
  function automatic logic [N-1:0] shift_stage(input logic [N-1:0] d, input op_e op,
                                               input logic sgn, input logic [2:0] k);
    logic [5:0]   amt;
    logic [N-1:0] hi_fill;
    amt     = 6'd1 << k;
    hi_fill = ~({N{1'b1}} >> amt);
    case (op)
      OP_SLL:  return d << amt;
      OP_SRL:  return d >> amt;
      OP_SRA:  return (d >> amt) | (sgn ? hi_fill : '0);
      default: return d;
    endcase
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    mask_d  = mask_q;
    sign_d  = sign_q;
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    stage = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (mask_q[i]) stage = 3'(i);
    end
`else
    stage = k_q;
    k_d   = k_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          data_d  = req_a;
          op_d    = op_e'(req_op);
          mask_d  = req_shamt;
          sign_d  = req_a[N-1];
          state_d = SHIFT;
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
          if (req_shamt == 5'd0) state_d = DONE;
`else
          k_d = 3'd0;
`endif
        end
      end
      SHIFT: begin
        if (mask_q[stage]) data_d = shift_stage(data_q, op_q, sign_q, stage);
        mask_d = mask_q & ~(5'b1 << stage);
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
        if (mask_d == 5'd0) state_d = DONE;
`else
        k_d = k_q + 3'd1;
        if (k_q == 3'd4) state_d = DONE;
`endif
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_SLL;
      data_q  <= '0;
      mask_q  <= '0;
      sign_q  <= 1'b0;
`ifndef SHIFT_SEQ_EARLY_EXIT_EN
      k_q     <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      sign_q  <= sign_d;
`ifndef SHIFT_SEQ_EARLY_EXIT_EN
      k_q     <= k_d;
`endif
    end
  end

  // Handshake outputs decode state only; ready is also held low for the duration of reset.
  assign req_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rsp_data  = data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: random and directed shifts against a plain-arithmetic model.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_a = '0;
  logic [4:0]  req_shamt = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        busy;

  shift_sequencer #(.N(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_shamt(req_shamt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   cycle = 0;
  int   errors = 0;
  int   checks = 0;
  bit   rr_en = 1'b1;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [4:0] s);
    case (op)
      2'b00:   return a << s;
      2'b01:   return a >> s;
      2'b10:   return 32'($signed(a) >>> s);
      default: return a;
    endcase
  endfunction

  function automatic int model_lat(input logic [4:0] s);
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
    return $countones(s);
`else
    return (s == s) ? 5 : 5;
`endif
  endfunction

  // Consumer back-pressure, changed away from both clock edges.
  initial forever begin
    @(posedge clk); #1;
    if (rr_en) rsp_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: latency on the rising rsp_valid, data on each handshake.
  initial begin : monitor
    exp_t e;
    bit   prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        if (rsp_valid && !prev_valid) begin
          if (sb.size() == 0) check("spurious_valid", {31'b0, rsp_valid}, 32'd0);
          else check("latency", 32'(cycle - sb[0].acc), 32'(sb[0].lat + 1));
        end
        if (rsp_valid && rsp_ready) begin
          if (sb.size() == 0) begin
            check("spurious_rsp", {31'b0, rsp_valid}, 32'd0);
          end else begin
            e = sb.pop_front();
            check("rsp_data", rsp_data, e.data);
          end
        end
        prev_valid = rsp_valid;
      end
    end
  end

  // Issue one request; push its expected result once acceptance is certain.
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [4:0] s,
                      output logic [31:0] exp_data);
    int   n = 0;
    exp_t e;
    exp_data = model(op, a, s);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_shamt = s;
    while (!req_ready) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        check("req_ready_timeout", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b0;
        return;
      end
    end
    e.data = exp_data;
    e.lat  = model_lat(s);
    e.acc  = cycle;
    @(posedge clk);
    sb.push_back(e);
    #1;
    req_valid = 1'b0;
    req_a     = $urandom;
    req_shamt = 5'($urandom);
    req_op    = 2'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin : stim
    logic [31:0] exp_d;
    int          n;

    #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_busy",      {31'b0, busy},      32'd0);
    check("rst_rsp_data",  rsp_data,           32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_req_ready", {31'b0, req_ready}, 32'd1);

    // Directed vectors
    send(2'b10, 32'h8000_0000, 5'd31, exp_d);
    send(2'b01, 32'h8000_0000, 5'd4,  exp_d);
    send(2'b10, 32'h8000_0000, 5'd4,  exp_d);
    send(2'b00, 32'h0000_0001, 5'd31, exp_d);
    send(2'b11, 32'h1234_5678, 5'd7,  exp_d);
    send(2'b10, 32'hDEAD_BEEF, 5'd0,  exp_d);
    send(2'b01, 32'hDEAD_BEEF, 5'h10, exp_d);
    drain();

    // Back-pressure in DONE
    rr_en = 1'b0;
    rsp_ready = 1'b0;
    send(2'b10, 32'h8000_0000, 5'd4, exp_d);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_seen", {31'b0, rsp_valid}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_data_hold", rsp_data, exp_d);
      check("bp_req_ready", {31'b0, req_ready}, 32'd0);
      check("bp_busy",      {31'b0, busy},      32'd1);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_busy_after",  {31'b0, busy},      32'd0);
    check("bp_ready_after", {31'b0, req_ready}, 32'd1);
    check("bp_valid_after", {31'b0, rsp_valid}, 32'd0);

    // Reset in the middle of an operation
    send(2'b00, 32'h0000_0003, 5'd31, exp_d);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    #1;
    check("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("mid_rst_rsp_data",  rsp_data,           32'd0);
    check("mid_rst_busy",      {31'b0, busy},      32'd0);
    check("mid_rst_req_ready", {31'b0, req_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_no_valid", {31'b0, rsp_valid}, 32'd0);
    end
    send(2'b00, 32'h0000_0001, 5'd1, exp_d);
    drain();

    // Random traffic with random consumer stalls
    rr_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      send(op, $urandom, 5'($urandom), exp_d);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
